// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - shared register map, control bits and phase table for stepper_ctrl
package stepper_pkg;

    // Register select values as seen on addr[3:2].
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_STEPS  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_START  = 0;
    localparam int CTRL_DIR    = 1;
    localparam int CTRL_HALF   = 2;
    localparam int CTRL_STOP   = 3;
    localparam int CTRL_HOLD   = 4;
    localparam int CTRL_IRQ_EN = 5;

    localparam int STATUS_BUSY = 0;
    localparam int STATUS_DONE = 1;

    // Half-step sequence, coil order A,B,A',B' from MSB to LSB; odd entries drive two coils.
    localparam logic [3:0] PHASE_SEQ [8] = '{
        4'b1000, 4'b1100, 4'b0100, 4'b0110,
        4'b0010, 4'b0011, 4'b0001, 4'b1001
    };

    typedef enum logic {IDLE, RUN} state_e;

endpackage

// File: rtl/stepper_channel.sv
// rtl/stepper_channel.sv - one unipolar stepper channel: registers, step timer, phase index and FSM
module stepper_channel
    import stepper_pkg::*;
#(
    parameter int PERIOD_W = 24,
    parameter int STEPS_W  = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_ctrl,
    input  logic        wr_period,
    input  logic        wr_steps,
    input  logic        wr_status,
    input  logic [31:0] wdata,
    input  logic [1:0]  rd_reg,
    output logic [31:0] rd_word,
    output logic [3:0]  coils,
    output logic        busy,
    output logic        irq
);

    state_e              state_d, state_q;
    logic                dir_d, dir_q, half_d, half_q, hold_d, hold_q;
    logic                irq_en_d, irq_en_q, done_d, done_q;
    logic [PERIOD_W-1:0] period_d, period_q, cnt_d, cnt_q;
    logic [STEPS_W-1:0]  remaining_d, remaining_q;
    logic [2:0]          index_d, index_q, step;
    logic                start, stop, set_done;
    logic                unused_wdata;

    assign unused_wdata = ^wdata;

    // A zero period behaves as one clock per step.
    function automatic logic [PERIOD_W-1:0] reload(input logic [PERIOD_W-1:0] p);
        return (p == '0) ? '0 : p - PERIOD_W'(1);
    endfunction

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        half_d      = half_q;
        hold_d      = hold_q;
        irq_en_d    = irq_en_q;
        done_d      = done_q;
        period_d    = period_q;
        cnt_d       = cnt_q;
        remaining_d = remaining_q;
        index_d     = index_q;
        set_done    = 1'b0;
        stop        = wr_ctrl && wdata[CTRL_STOP];
        start       = wr_ctrl && wdata[CTRL_START] && !wdata[CTRL_STOP];
        step        = half_q ? 3'd1 : 3'd2;

        if (wr_ctrl) begin
            dir_d    = wdata[CTRL_DIR];
            half_d   = wdata[CTRL_HALF];
            hold_d   = wdata[CTRL_HOLD];
            irq_en_d = wdata[CTRL_IRQ_EN];
        end
        if (wr_period) begin
            period_d = wdata[PERIOD_W-1:0];
        end

        case (state_q)
            IDLE: begin
                if (wr_steps) begin
                    remaining_d = wdata[STEPS_W-1:0];
                end
                if (start) begin
                    if (remaining_q != '0) begin
                        state_d = RUN;
                        cnt_d   = reload(period_q);
                        // Full mode must sit on a two-coil entry before the first step.
                        if (!wdata[CTRL_HALF] && !index_q[0]) begin
                            index_d = index_q + 3'd1;
                        end
                    end else begin
                        set_done = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (remaining_q == '0) begin
                    state_d  = IDLE;
                    set_done = 1'b1;
                end else if (cnt_q == '0) begin
                    index_d     = dir_q ? index_q + step : index_q - step;
                    remaining_d = remaining_q - STEPS_W'(1);
                    cnt_d       = reload(period_q);
                end else begin
                    cnt_d = cnt_q - PERIOD_W'(1);
                end
            end
        endcase

        if (wr_status && wdata[STATUS_DONE]) begin
            done_d = 1'b0;
        end
        if (set_done) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            dir_q       <= 1'b0;
            half_q      <= 1'b0;
            hold_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            period_q    <= '0;
            cnt_q       <= '0;
            remaining_q <= '0;
            index_q     <= 3'd1;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            half_q      <= half_d;
            hold_q      <= hold_d;
            irq_en_q    <= irq_en_d;
            done_q      <= done_d;
            period_q    <= period_d;
            cnt_q       <= cnt_d;
            remaining_q <= remaining_d;
            index_q     <= index_d;
        end
    end

    always_comb begin
        rd_word = '0;
        case (rd_reg)
            REG_CTRL: begin
                rd_word[CTRL_DIR]    = dir_q;
                rd_word[CTRL_HALF]   = half_q;
                rd_word[CTRL_HOLD]   = hold_q;
                rd_word[CTRL_IRQ_EN] = irq_en_q;
            end
            REG_PERIOD: rd_word = 32'(period_q);
            REG_STEPS:  rd_word = 32'(remaining_q);
            REG_STATUS: begin
                rd_word[31:16]       = 16'(remaining_q);
                rd_word[STATUS_DONE] = done_q;
                rd_word[STATUS_BUSY] = (state_q == RUN);
            end
        endcase
    end

    assign busy  = (state_q == RUN);
    assign coils = (busy || hold_q) ? PHASE_SEQ[index_q] : 4'b0000;
    assign irq   = done_q && irq_en_q;

endmodule

// File: rtl/stepper_ctrl.sv
// rtl/stepper_ctrl.sv - memory-mapped multi-channel stepper driver: decode, read register, irq merge
module stepper_ctrl
    import stepper_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int PERIOD_W = 24,
    parameter int STEPS_W  = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                sel,
    input  logic                wren,
    input  logic [7:0]          addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic [4*NUM_CH-1:0] coils,
    output logic [NUM_CH-1:0]   busy,
    output logic                irq
);

    logic [3:0]        ch_sel;
    logic [1:0]        reg_sel;
    logic [NUM_CH-1:0] wr_ctrl, wr_period, wr_steps, wr_status, ch_irq;
    logic [31:0]       rd_word [NUM_CH];
    logic [31:0]       rdata_d, rdata_q;
    logic              unused_addr;

    assign ch_sel      = addr[7:4];
    assign reg_sel     = addr[3:2];
    assign unused_addr = ^addr[1:0];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic hit;
        assign hit          = sel && wren && (ch_sel == 4'(c));
        assign wr_ctrl[c]   = hit && (reg_sel == REG_CTRL);
        assign wr_period[c] = hit && (reg_sel == REG_PERIOD);
        assign wr_steps[c]  = hit && (reg_sel == REG_STEPS);
        assign wr_status[c] = hit && (reg_sel == REG_STATUS);

        stepper_channel #(
            .PERIOD_W (PERIOD_W),
            .STEPS_W  (STEPS_W)
        ) u_channel (
            .clock     (clock),
            .reset     (reset),
            .wr_ctrl   (wr_ctrl[c]),
            .wr_period (wr_period[c]),
            .wr_steps  (wr_steps[c]),
            .wr_status (wr_status[c]),
            .wdata     (wdata),
            .rd_reg    (reg_sel),
            .rd_word   (rd_word[c]),
            .coils     (coils[4*c +: 4]),
            .busy      (busy[c]),
            .irq       (ch_irq[c])
        );
    end

    // Unpopulated channels fall through to zero.
    always_comb begin
        rdata_d = rdata_q;
        if (sel) begin
            rdata_d = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_sel == 4'(c)) begin
                    rdata_d = rd_word[c];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
    assign irq   = |ch_irq;

endmodule
